// File: rtl/rr_arb4_dec_if.sv
// rr_arb4_dec_if: request/grant bundle between requesters and the rr_arb4_dec arbiter
interface rr_arb4_dec_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt_n;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       hold_tmo;

    modport master (output en, req, input gnt_n, gnt_idx, gnt_vld, hold_tmo);
    modport slave  (input en, req, output gnt_n, gnt_idx, gnt_vld, hold_tmo);
endinterface

// File: rtl/rr_arb4_dec.sv
// rr_arb4_dec: 4-way round-robin arbiter with active-low one-cold grant, bounded hold and dead cycle
module rr_arb4_dec #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb4_dec_if.slave  arb
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gnt_n_q, gnt_n_d;
    logic               tmo_q, tmo_d;
    logic [1:0]         win;
    logic               rel, expire;

    // First set request at or after p, wrapping mod 4
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w, j;
        w = p;
        for (int k = 3; k >= 0; k--) begin
            j = p + 2'(k);
            if (r[j]) w = j;
        end
        return w;
    endfunction

    assign win    = pick(arb.req, ptr_q);
    assign rel    = !arb.req[idx_q];
    assign expire = cnt_q == CNT_W'(MAX_HOLD - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_n_d = 4'hF;
        tmo_d   = 1'b0;
        if (state_q == IDLE) begin
            if (arb.en && |arb.req) begin
                state_d = GRANT;
                idx_d   = win;
                gnt_n_d = ~(4'b0001 << win);
                cnt_d   = '0;
            end
        end else if (!arb.en || rel || expire) begin
            state_d = IDLE;
            ptr_d   = idx_q + 2'd1;
            tmo_d   = arb.en && !rel;
        end else begin
            gnt_n_d = gnt_n_q;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_n_q <= 4'hF;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_n_q <= gnt_n_d;
            tmo_q   <= tmo_d;
        end
    end

    assign arb.gnt_n    = gnt_n_q;
    assign arb.gnt_idx  = idx_q;
    assign arb.gnt_vld  = ~&gnt_n_q;
    assign arb.hold_tmo = tmo_q;
endmodule

// File: tb/tb_rr_arb4_dec.sv
// tb_rr_arb4_dec: directed and randomized checks of rr_arb4_dec against a behavioural model
module tb_rr_arb4_dec;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass = 0;
    int   total = 0;

    rr_arb4_dec_if bus();
    rr_arb4_dec #(.MAX_HOLD(MH), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .arb(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: who owns the resource, for how many cycles, and who is favoured next
    int         m_own, m_held, m_prio;
    logic [1:0] m_idx;
    logic       m_tmo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_held = 0; m_prio = 0; m_idx = 0; m_tmo = 0;
        end else if (m_own < 0) begin
            m_tmo = 0;
            if (bus.en && bus.req != 0) begin
                for (int k = 3; k >= 0; k--)
                    if (bus.req[(m_prio + k) % 4]) m_own = (m_prio + k) % 4;
                m_held = 1;
                m_idx = 2'(m_own);
            end
        end else if (!bus.en || !bus.req[m_own] || m_held == MH) begin
            m_tmo = bus.en && bus.req[m_own];
            m_prio = (m_own + 1) % 4;
            m_own = -1;
        end else begin
            m_held++;
            m_tmo = 0;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n) begin
            e = 4'hF;
            if (m_own >= 0) e[m_own] = 1'b0;
            chk("model_gnt_n", 32'(bus.gnt_n), 32'(e));
            chk("model_gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
            chk("model_gnt_vld", 32'(bus.gnt_vld), 32'(m_own >= 0));
            chk("model_hold_tmo", 32'(bus.hold_tmo), 32'(m_tmo));
        end
    end

    task automatic rand_phase(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.en = $urandom_range(0, 15) != 0;
            for (int b = 0; b < 4; b++)
                bus.req[b] = bus.req[b] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        bus.en = 1'b1;
        bus.req = 4'b1111;
        #12;
        chk("reset_gnt_n", 32'(bus.gnt_n), 32'hF);
        chk("reset_gnt_vld", 32'(bus.gnt_vld), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("first_gnt_n", 32'(bus.gnt_n), 32'hE);
        chk("first_gnt_idx", 32'(bus.gnt_idx), 32'h0);

        rst_n = 1'b0;
        bus.req = 4'b0100;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold3_gnt_n", 32'(bus.gnt_n), 32'hB);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        chk("release_gnt_n", 32'(bus.gnt_n), 32'hF);
        chk("release_tmo", 32'(bus.hold_tmo), 32'h0);
        bus.req = 4'b1111;
        @(negedge clk);
        chk("ptr3_idx", 32'(bus.gnt_idx), 32'h3);
        chk("ptr3_gnt_n", 32'(bus.gnt_n), 32'h7);
        repeat (7) begin
            @(negedge clk);
            chk("maxhold_gnt_n", 32'(bus.gnt_n), 32'h7);
        end
        @(negedge clk);
        chk("tmo_pulse", 32'(bus.hold_tmo), 32'h1);
        chk("tmo_dead_gnt_n", 32'(bus.gnt_n), 32'hF);
        @(negedge clk);
        chk("after_tmo_gnt_n", 32'(bus.gnt_n), 32'hE);
        chk("after_tmo_tmo", 32'(bus.hold_tmo), 32'h0);

        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("en_pre_gnt_n", 32'(bus.gnt_n), 32'hB);
        bus.en = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        chk("en_drop_gnt_n", 32'(bus.gnt_n), 32'hF);
        chk("en_drop_tmo", 32'(bus.hold_tmo), 32'h0);
        @(negedge clk);
        chk("en_off_gnt_n", 32'(bus.gnt_n), 32'hF);
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_back_idx", 32'(bus.gnt_idx), 32'h3);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt_n", 32'(bus.gnt_n), 32'hF);
        chk("async_rst_vld", 32'(bus.gnt_vld), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idx", 32'(bus.gnt_idx), 32'h0);
        chk("post_rst_gnt_n", 32'(bus.gnt_n), 32'hE);

        rand_phase(1500);
        @(negedge clk);
        bus.en = 1'b1;
        bus.req = 4'b1010;
        repeat (60) @(negedge clk);
        rand_phase(1500);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
